tdm_demux_1x8: RTL

Sequential 1-to-8 time-division demultiplexer. It is the receive-side counterpart of the 8x1 mux path in the data-routing library. A serial bit stream, one bit per valid beat, is distributed into 8 lanes by an internal lane counter, or by an external select in direct mode. Completed 8-bit frames are presented on a registered parallel bus with a one-cycle frame strobe.

---
 rtl/tdm_demux_1x8_if.sv | 38 +++
 rtl/tdm_demux_1x8.sv | 124 ++++++++++++
 2 files changed

// File: rtl/tdm_demux_1x8_if.sv
// tdm_demux_1x8_if: bundles the serial-side inputs and the parallel-side
// outputs of the 1-to-8 TDM demultiplexer.
//   din, din_valid       serial bit and its beat qualifier
//   frame_start          synchronous resync pulse
//   sel_mode, sel        0 = counter-driven lanes, 1 = direct lane select
//   y, frame_valid       registered parallel frame and its one-cycle strobe
//   cur_lane             lane the next auto-mode beat will write
//   parity_err           only with TDM_DEMUX_PARITY_EN: frame parity check result
// modport master: the stream source; modport slave: the demultiplexer.
interface tdm_demux_1x8_if;
  logic       din;
  logic       din_valid;
  logic       frame_start;
  logic       sel_mode;
  logic [2:0] sel;
  logic [7:0] y;
  logic       frame_valid;
  logic [2:0] cur_lane;
`ifdef TDM_DEMUX_PARITY_EN
  logic       parity_err;
`endif

  modport master (
    output din, din_valid, frame_start, sel_mode, sel,
`ifdef TDM_DEMUX_PARITY_EN
    input  parity_err,
`endif
    input  y, frame_valid, cur_lane
  );

  modport slave (
    input  din, din_valid, frame_start, sel_mode, sel,
`ifdef TDM_DEMUX_PARITY_EN
    output parity_err,
`endif
    output y, frame_valid, cur_lane
  );
endinterface

// File: rtl/tdm_demux_1x8.sv
// tdm_demux_1x8: sequential 1-to-8 time-division demultiplexer.
// Auto mode collects 8 valid beats into a shadow register (lane counter
// driven) and publishes the completed frame on y with a one-cycle
// frame_valid strobe. Direct mode writes y[sel] on every valid beat.
// frame_start or a change of sel_mode resynchronises the lane counter and
// discards the partial frame; y is kept.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    tdm_demux_1x8_if.slave (din, din_valid, frame_start, sel_mode,
//          sel, y, frame_valid, cur_lane[, parity_err])
// Optional macro TDM_DEMUX_PARITY_EN: auto frames gain a 9th (even parity)
// beat; y/frame_valid update on that beat and parity_err reports the check.
module tdm_demux_1x8 #(
  parameter int LANES      = 8,
  parameter int FIRST_LANE = 0
) (
  input logic            clk,
  input logic            rst_n,
  tdm_demux_1x8_if.slave bus
);

  localparam logic [2:0] FIRST = 3'(FIRST_LANE);
  localparam logic [2:0] LAST  = 3'(LANES - 1);

  logic [LANES-1:0] shadow_q, shadow_d;
  logic [LANES-1:0] y_q, y_d;
  logic [2:0]       cur_lane_q, cur_lane_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sel_mode_q, sel_mode_d;
`ifdef TDM_DEMUX_PARITY_EN
  logic             parity_phase_q, parity_phase_d;
  logic             parity_err_q, parity_err_d;
`endif

  logic             resync;
  logic [2:0]       lane;

  always_comb begin
    shadow_d      = shadow_q;
    y_d           = y_q;
    cur_lane_d    = cur_lane_q;
    frame_valid_d = 1'b0;
    sel_mode_d    = bus.sel_mode;
`ifdef TDM_DEMUX_PARITY_EN
    parity_phase_d = parity_phase_q;
    parity_err_d   = parity_err_q;
`endif
    resync = bus.frame_start | (bus.sel_mode != sel_mode_q);
    lane   = cur_lane_q;

    // Resync is applied first so a beat in the same cycle lands on FIRST
    // and sees an empty shadow.
    if (resync) begin
      shadow_d   = '0;
      cur_lane_d = FIRST;
      lane       = FIRST;
`ifdef TDM_DEMUX_PARITY_EN
      parity_phase_d = 1'b0;
`endif
    end

    if (bus.din_valid) begin
      if (bus.sel_mode) begin
        y_d[bus.sel] = bus.din;
      end else
`ifdef TDM_DEMUX_PARITY_EN
      if (parity_phase_q && !resync) begin
        // Beat 9: publish the held frame together with its parity result.
        y_d            = shadow_q;
        frame_valid_d  = 1'b1;
        parity_err_d   = (^shadow_q) ^ bus.din;
        parity_phase_d = 1'b0;
      end else
`endif
      begin
        shadow_d[lane] = bus.din;
        if (lane == LAST) begin
          cur_lane_d = '0;
`ifdef TDM_DEMUX_PARITY_EN
          parity_phase_d = 1'b1;
`else
          y_d           = shadow_d;
          frame_valid_d = 1'b1;
`endif
        end else begin
          cur_lane_d = lane + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q      <= '0;
      y_q           <= '0;
      cur_lane_q    <= FIRST;
      frame_valid_q <= 1'b0;
      sel_mode_q    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_phase_q <= 1'b0;
      parity_err_q   <= 1'b0;
`endif
    end else begin
      shadow_q      <= shadow_d;
      y_q           <= y_d;
      cur_lane_q    <= cur_lane_d;
      frame_valid_q <= frame_valid_d;
      sel_mode_q    <= sel_mode_d;
`ifdef TDM_DEMUX_PARITY_EN
      parity_phase_q <= parity_phase_d;
      parity_err_q   <= parity_err_d;
`endif
    end
  end

  assign bus.y           = y_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.cur_lane    = cur_lane_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign bus.parity_err  = parity_err_q;
`endif

endmodule
